vram_scroll_ctrl: RTL
=====================

// Module: vram_scroll_ctrl
// PURPOSE
//  Owns the CPU-side (Avalon) port of the 600x32 text VRAM and shares it between the
//  CPU slave interface and an internal scroll/clear engine. Scroll copies rows 1..29
//  up one row and fills row 29. Clear fills the whole screen. While the engine runs,
//  CPU accesses are stalled with waitrequest. The VGA read port of the VRAM is untouched.
// PARAMETERS
//  WORDS_PER_ROW  20            32-bit words per text row (80 chars, 4 per word)
//  NUM_ROWS       30            text rows; total words = WORDS_PER_ROW*NUM_ROWS (600)
//  FILL_WORD      32'h00000000  word written by clear and into the scrolled-in last row
// PORTS
//  CLK              in   1   system clock
//  RESET            in   1   asynchronous, active-high reset
//  CPU_READ         in   1   Avalon read request
//  CPU_WRITE        in   1   Avalon write request
//  CPU_BYTE_EN      in   4   Avalon byte enables
//  CPU_ADDR         in   10  Avalon word address
//  CPU_WRITEDATA    in   32  Avalon write data
//  CPU_READDATA     out  32  Avalon read data, fixed read latency 1
//  CPU_WAITREQUEST  out  1   stall; high while engine busy and CPU_READ|CPU_WRITE
//  SCROLL_REQ       in   1   single-cycle pulse: start scroll
//  CLEAR_REQ        in   1   single-cycle pulse: start clear
//  BUSY             out  1   engine active (any state other than IDLE)
//  DONE             out  1   one-cycle pulse when an operation completes
//  MEM_WRITE        out  1   to VRAM AVL_WRITE
//  MEM_BYTE_EN      out  4   to VRAM AVL_BYTE_EN
//  MEM_ADDR         out  10  to VRAM AVL_ADDR
//  MEM_WRITEDATA    out  32  to VRAM AVL_WRITEDATA
//  MEM_READDATA     in   32  from VRAM AVL_READDATA (registered, valid 1 cycle after addr)
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, BUSY=0, DONE=0; MEM_WRITE=0 unless CPU_WRITE is
//    asserted in IDLE. Reset mid-operation aborts immediately; partial VRAM contents remain.
//  - States: IDLE, SCR_RD, SCR_WR, FILL, FIN. Word counter idx spans 0..599.
//  - IDLE: MEM_* combinationally pass through CPU_* (MEM_ADDR=CPU_ADDR, MEM_WRITE=CPU_WRITE).
//    CPU_WAITREQUEST=0. CPU_READDATA=MEM_READDATA at all times.
//  - IDLE + CLEAR_REQ -> FILL with idx=0. IDLE + SCROLL_REQ -> SCR_RD with idx=0.
//    Both asserted in the same cycle: CLEAR wins. A CPU access in that same cycle is still
//    accepted (pass-through); the engine owns the port from the next cycle.
//  - SCR_RD: MEM_ADDR=idx+WORDS_PER_ROW, MEM_WRITE=0 -> SCR_WR.
//  - SCR_WR: MEM_ADDR=idx, MEM_WRITE=1, BYTE_EN=4'hF, WRITEDATA=MEM_READDATA.
//    If idx==(NUM_ROWS-1)*WORDS_PER_ROW-1 (579): idx<=580 -> FILL. Else idx++ -> SCR_RD.
//  - FILL: MEM_ADDR=idx, MEM_WRITE=1, BYTE_EN=4'hF, WRITEDATA=FILL_WORD.
//    If idx==599 -> FIN, else idx++.
//  - FIN: DONE=1 for exactly one cycle, BUSY=1 -> IDLE.
//  - Cycle counts, from the request cycle to DONE inclusive:
//    scroll = 1 + 2*580 + 20 + 1 = 1182; clear = 1 + 600 + 1 = 602.
//  - Busy (non-IDLE): CPU_WAITREQUEST=CPU_READ|CPU_WRITE. CPU inputs are ignored.
//    SCROLL_REQ and CLEAR_REQ are ignored (not queued).
//  - A CPU read accepted in the cycle of the transition to busy returns data one cycle
//    later on CPU_READDATA. This is valid because SCR_RD/FILL only change MEM_ADDR in that cycle.
//  - The engine never reads or writes addresses >= 600. idx width is 10 bits, no wrap.
// TESTING
//  - Idle CPU write addr 5 data 32'hA1B2C3D4 BE=4'b0101, then read addr 5 ->
//    readdata 32'h00B200D4 (from zeroed mem) one cycle after read; waitrequest stays 0.
//  - Preload mem[i]=i, pulse SCROLL_REQ -> DONE 1182 cycles later (request cycle = 1);
//    mem[i]=i+20 for i<580, mem[580..599]=FILL_WORD.
//  - Preload mem[i]=32'hFFFFFFFF, pulse CLEAR_REQ -> DONE after 602 cycles; all 600 words = 0.
//  - SCROLL_REQ and CLEAR_REQ in the same cycle -> clear performed (602 cycles); no scroll copy.
//  - CPU_WRITE held during scroll -> waitrequest=1 until cycle after DONE.
//    The write then lands, and the scrolled data is not corrupted.
//  - Assert RESET at idx=100 of scroll -> BUSY=0, DONE never pulses.
//    mem[0..99] scrolled, mem[100..] unchanged; a following SCROLL_REQ runs normally.

Source files
------------

// File: rtl/vram_scroll_ctrl_if.sv
// CPU-side Avalon bus and VRAM port bundle for the text VRAM scroll/clear controller.
// slave: controller view; master: CPU and VRAM environment view.
interface vram_scroll_ctrl_if;
    logic        CPU_READ;
    logic        CPU_WRITE;
    logic [3:0]  CPU_BYTE_EN;
    logic [9:0]  CPU_ADDR;
    logic [31:0] CPU_WRITEDATA;
    logic [31:0] CPU_READDATA;
    logic        CPU_WAITREQUEST;
    logic        MEM_WRITE;
    logic [3:0]  MEM_BYTE_EN;
    logic [9:0]  MEM_ADDR;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;

    modport slave (
        input  CPU_READ, CPU_WRITE, CPU_BYTE_EN, CPU_ADDR, CPU_WRITEDATA, MEM_READDATA,
        output CPU_READDATA, CPU_WAITREQUEST, MEM_WRITE, MEM_BYTE_EN, MEM_ADDR, MEM_WRITEDATA
    );

    modport master (
        output CPU_READ, CPU_WRITE, CPU_BYTE_EN, CPU_ADDR, CPU_WRITEDATA, MEM_READDATA,
        input  CPU_READDATA, CPU_WAITREQUEST, MEM_WRITE, MEM_BYTE_EN, MEM_ADDR, MEM_WRITEDATA
    );
endinterface

// File: rtl/vram_scroll_ctrl.sv
// Arbitrates the text VRAM Avalon port between the CPU and a scroll/clear engine.
// The engine copies rows up by one (read/write pairs) and fills words with FILL_WORD.
module vram_scroll_ctrl #(
    parameter int unsigned WORDS_PER_ROW = 20,
    parameter int unsigned NUM_ROWS      = 30,
    parameter logic [31:0] FILL_WORD     = 32'h00000000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    vram_scroll_ctrl_if.slave    bus,
    input  logic                 SCROLL_REQ,
    input  logic                 CLEAR_REQ,
    output logic                 BUSY,
    output logic                 DONE
);
    localparam logic [9:0] RowStep  = 10'(WORDS_PER_ROW);
    localparam logic [9:0] LastCopy = 10'((NUM_ROWS - 1) * WORDS_PER_ROW - 1);
    localparam logic [9:0] LastWord = 10'(NUM_ROWS * WORDS_PER_ROW - 1);

    typedef enum logic [2:0] {StIdle, StScrRd, StScrWr, StFill, StFin} state_e;

    state_e     state_q, state_d;
    logic [9:0] idx_q, idx_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Read data comes straight from the VRAM register; the engine only moves the
    // address after the transition cycle, so a read accepted then still returns valid data.
    assign bus.CPU_READDATA = bus.MEM_READDATA;
    assign BUSY             = (state_q != StIdle);
    assign DONE             = (state_q == StFin);

    always_comb begin
        state_d             = state_q;
        idx_d               = idx_q;
        bus.MEM_WRITE       = 1'b0;
        bus.MEM_BYTE_EN     = 4'hF;
        bus.MEM_ADDR        = idx_q;
        bus.MEM_WRITEDATA   = FILL_WORD;
        bus.CPU_WAITREQUEST = bus.CPU_READ | bus.CPU_WRITE;

        unique case (state_q)
            StIdle: begin
                bus.MEM_WRITE       = bus.CPU_WRITE;
                bus.MEM_BYTE_EN     = bus.CPU_BYTE_EN;
                bus.MEM_ADDR        = bus.CPU_ADDR;
                bus.MEM_WRITEDATA   = bus.CPU_WRITEDATA;
                bus.CPU_WAITREQUEST = 1'b0;
                if (CLEAR_REQ) begin
                    state_d = StFill;
                    idx_d   = '0;
                end else if (SCROLL_REQ) begin
                    state_d = StScrRd;
                    idx_d   = '0;
                end
            end
            StScrRd: begin
                bus.MEM_ADDR = idx_q + RowStep;
                state_d      = StScrWr;
            end
            StScrWr: begin
                bus.MEM_WRITE     = 1'b1;
                bus.MEM_WRITEDATA = bus.MEM_READDATA;
                idx_d             = idx_q + 10'd1;
                state_d           = (idx_q == LastCopy) ? StFill : StScrRd;
            end
            StFill: begin
                bus.MEM_WRITE = 1'b1;
                if (idx_q == LastWord) begin
                    state_d = StFin;
                end else begin
                    idx_d = idx_q + 10'd1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end
endmodule
